// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin I2C bus arbiter.
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } t_i2c_arb_state;

    localparam int c_i2c_arb_max_req       = 8;
    localparam int c_i2c_arb_guard_default = 4;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping past the top index.
module rr_priority_picker #(
    parameter int p_num_req = 2,
    parameter int p_idx_w   = 1
) (
    input  logic [p_num_req-1:0] i_req,
    input  logic [p_idx_w-1:0]   i_ptr,
    output logic [p_num_req-1:0] o_pick,
    output logic [p_idx_w-1:0]   o_idx,
    output logic                 o_valid
);

    // Scan upward from the pointer, keeping only the first hit
    always_comb begin : p_pick
        int                 v_sum;
        logic [p_idx_w-1:0] v_idx;
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        v_sum   = 0;
        v_idx   = '0;
        for (int k = 0; k < p_num_req; k++) begin
            v_sum = int'(i_ptr) + k;
            v_idx = (v_sum >= p_num_req) ? p_idx_w'(v_sum - p_num_req) : p_idx_w'(v_sum);
            if (!o_valid && i_req[v_idx]) begin
                o_valid       = 1'b1;
                o_pick[v_idx] = 1'b1;
                o_idx         = v_idx;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Exclusive round-robin owner of the shared I2C pins with a bus-free guard
// between tenures. Optional grant watchdog: define I2C_ARB_WATCHDOG_EN.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int  p_num_req        = 2,
    parameter int  p_guard_cycles   = c_i2c_arb_guard_default,
    parameter int  p_timeout_cycles = 1_000_000,
    localparam int c_idx_w          = f_max(1, $clog2(p_num_req)),
    localparam int c_cnt_w          = f_max(1, $clog2(f_max(p_guard_cycles, p_timeout_cycles) + 1))
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [p_num_req-1:0] i_req,
    input  logic [p_num_req-1:0] i_done,
    output logic [p_num_req-1:0] o_grant,
    output logic [c_idx_w-1:0]   o_owner,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam logic [c_cnt_w-1:0] c_guard_load =
        (p_guard_cycles > 0) ? c_cnt_w'(p_guard_cycles - 1) : '0;

    t_i2c_arb_state       r_state;
    t_i2c_arb_state       w_next_state;
    logic [p_num_req-1:0] r_grant;
    logic [p_num_req-1:0] w_next_grant;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_idx_w-1:0]   w_next_owner;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   w_next_ptr;
    logic [c_idx_w-1:0]   w_owner_inc;
    logic [c_idx_w-1:0]   w_pick_ptr;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic [p_num_req-1:0] w_pick;
    logic                 w_pick_valid;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_next_cnt;
    logic                 r_busy;
    logic                 w_release;
    logic                 w_expire;
    logic                 w_wd_tick;

    assign w_owner_inc = (r_owner == c_idx_w'(p_num_req - 1)) ? '0 : r_owner + c_idx_w'(1'b1);
    // With a zero guard the picker must already see the post-release pointer
    assign w_pick_ptr  = (r_state == GRANT) ? w_owner_inc : r_ptr;
    assign w_release   = i_done[r_owner] | ~i_req[r_owner];

    rr_priority_picker #(
        .p_num_req (p_num_req),
        .p_idx_w   (c_idx_w)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (w_pick_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

`ifdef I2C_ARB_WATCHDOG_EN
    logic r_timeout;

    assign w_wd_tick = 1'b1;
    assign w_expire  = (r_state == GRANT) && !w_release && (r_cnt == c_cnt_w'(p_timeout_cycles));

    // One-cycle pulse marking a watchdog revocation
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_wd_tick = 1'b0;
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Next-state and next-register values for the arbitration FSM
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_owner = r_owner;
        w_next_ptr   = r_ptr;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_grant = w_pick;
                    w_next_owner = w_pick_idx;
                    w_next_cnt   = '0;
                    w_next_state = GRANT;
                end else begin
                    w_next_grant = '0;
                end
            end
            GRANT: begin
                if (w_release || w_expire) begin
                    w_next_grant = '0;
                    w_next_ptr   = w_owner_inc;
                    w_next_cnt   = c_guard_load;
                    if (p_guard_cycles > 0) begin
                        w_next_state = GUARD;
                    end else if (w_pick_valid) begin
                        w_next_grant = w_pick;
                        w_next_owner = w_pick_idx;
                        w_next_cnt   = '0;
                        w_next_state = GRANT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_next_cnt = w_wd_tick ? r_cnt + c_cnt_w'(1'b1) : r_cnt;
                end
            end
            GUARD: begin
                if (r_cnt == '0) begin
                    if (w_pick_valid) begin
                        w_next_grant = w_pick;
                        w_next_owner = w_pick_idx;
                        w_next_cnt   = '0;
                        w_next_state = GRANT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_next_cnt = r_cnt - c_cnt_w'(1'b1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_owner <= w_next_owner;
            r_ptr   <= w_next_ptr;
            r_cnt   <= w_next_cnt;
            r_busy  <= (w_next_state != IDLE);
        end
    end

    assign o_grant = r_grant;
    assign o_owner = r_owner;
    assign o_busy  = r_busy;

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares the single I2C pin pair (SDA/SCL) between several I2C transaction sources. Sources include the OV7670 ROM configuration sequencer and the MLX90640 readout engine. Grants are exclusive and round-robin, each owner is held until it releases, and a bus-free guard interval is enforced between owners. The block sits beside the I2C masters in the top level; its one-hot grant gates which master's command stream and open-drain drivers reach the pins.

## Interface
- `p_num_req`, default 2: number of requesters, 2..8.
- `p_guard_cycles`, default 4: idle cycles with no grant between two owners; 0 allowed.
- `p_timeout_cycles`, default 1_000_000: maximum cycles one grant may be held; used only with the watchdog macro.
- `i_clk`, in, 1: system clock; the only clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_req`, in, p_num_req: level request per source; held until the source is done.
- `i_done`, in, p_num_req: one-cycle release pulse per source; ignored unless that source owns the bus.
- `o_grant`, out, p_num_req: one-hot or zero, registered.
- `o_owner`, out, max(1,$clog2(p_num_req)): index of the current or last owner.
- `o_busy`, out, 1: high when state ≠ IDLE.
- `o_timeout`, out, 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GRANT, GUARD.
- Reset values: o_grant=0, o_owner=0, o_busy=0, o_timeout=0, RR pointer=0, counter=0, state IDLE. Assertion is asynchronous, so all grants drop immediately even mid-transaction.
- IDLE: if any i_req bit is set, pick the first set bit searching from the RR pointer upward with wrap. Register the grant bit and o_owner, then go to GRANT.
- GRANT: hold the grant. A release is i_done[owner]=1 or i_req[owner]=0. On release, clear the grant, set RR pointer = owner+1 mod p_num_req, and load counter = p_guard_cycles-1.
  - If p_guard_cycles>0: go to GUARD.
  - If p_guard_cycles=0: re-arbitrate in the same cycle. Either go to GRANT with the new owner, or go to IDLE.
- GUARD: grant stays zero and the counter decrements. When counter=0, re-arbitrate as in IDLE: go to GRANT if a request is pending, else go to IDLE.
- Requests from non-owners during GRANT or GUARD wait; they are never lost because i_req is a level.
- A release and a new request arriving in the same cycle: the release wins, and the new request is served after the guard.
- i_done on a non-owner bit is ignored.
- Fairness: with all requests held, owners rotate 0,1,…,N-1,0. No source waits more than N-1 tenures.
- Counter width: $clog2(max(p_guard_cycles,p_timeout_cycles)+1).

## Timing
- Request sampled in IDLE at cycle T gives o_grant at T+1.
- Release sampled at T gives o_grant=0 at T+1. The next grant is at T+p_guard_cycles+1, or at T+1 when p_guard_cycles=0.
- o_busy rises with the grant and falls on the cycle IDLE is entered.
- o_owner updates only when a grant is issued and keeps its value through GUARD and IDLE.

## Configuration
- Macro `I2C_ARB_WATCHDOG_EN`.
- When defined: a counter runs in GRANT and clears on each new grant. When it reaches p_timeout_cycles with no release, the next cycle clears the grant, pulses o_timeout, advances the RR pointer past the owner, and enters GUARD.
- When undefined: no watchdog counter is built, o_timeout is tied to 0, and a grant is held indefinitely.

## Structure
- package_i2c gains:
  - typedef enum `t_i2c_arb_state` {IDLE, GRANT, GUARD};
  - localparams `c_i2c_arb_max_req` = 8 and `c_i2c_arb_guard_default` = 4.
- Sub-module `rr_priority_picker`: combinational. Inputs are the request vector and the RR pointer; outputs are the one-hot pick, its index and valid. It is instantiated once.

## Test plan
All scenarios use p_num_req=2 and p_guard_cycles=4; where relevant, p_timeout_cycles=20 with the macro defined.
- i_req=2'b01 at cycle 0 → o_grant=01 and o_owner=0 at cycle 1. i_done[0] pulsed at cycle 10 → o_grant=00 at cycle 11, o_busy=0 at cycle 15.
- i_req=2'b11 held constantly, each owner pulses done 8 cycles after its grant → grants alternate 01,10,01 with exactly 4 zero-grant cycles between tenures.
- Owner 0 holds, i_done[1] pulsed while req1 is pending → ignored, and o_grant stays 01.
- Owner 1 deasserts i_req[1] at cycle 7 without done → o_grant=00 at cycle 8, treated as a release.
- Watchdog build: req0 held and no done → o_grant drops and o_timeout=1 for one cycle exactly 21 cycles after the grant (cycle 22). Pending req1 is granted 4 cycles later.
- i_rst asserted mid-GRANT between clock edges → o_grant=0 and o_busy=0 immediately. After release, i_req=11 → owner 0 is granted first.
